// File: rtl/vmask_cpop_seq_if.sv
// Bundle of request, mask-operand, popcount-stage and result channels for the
// vcpop.m sequencer. The slave side is the sequencer itself.
interface vmask_cpop_seq_if #(
   parameter int DATA_WIDTH = 64,
   parameter int VL_BITS    = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic [VL_BITS-1:0]    req_vl;
   logic                  req_vm;

   logic                  src_valid;
   logic                  src_ready;
   logic [DATA_WIDTH-1:0] src_mask;
   logic [DATA_WIDTH-1:0] src_v0;

   logic [DATA_WIDTH-1:0] pc_m0;
   logic                  pc_valid;
   logic [DATA_WIDTH-1:0] pc_count;
   logic [DATA_WIDTH-1:0] pc_sum;

   logic                  res_valid;
   logic [DATA_WIDTH-1:0] res_data;
   logic                  res_ready;

   modport master (
      output req_valid, req_vl, req_vm, src_valid, src_mask, src_v0, pc_sum, res_ready,
      input  req_ready, src_ready, pc_m0, pc_valid, pc_count, res_valid, res_data
   );

   modport slave (
      input  req_valid, req_vl, req_vm, src_valid, src_mask, src_v0, pc_sum, res_ready,
      output req_ready, src_ready, pc_m0, pc_valid, pc_count, res_valid, res_data
   );
endinterface

// File: rtl/vmask_cpop_seq.sv
// vcpop.m sequencer: streams mask beats with v0/tail masking into a one-cycle
// popcount stage, carries the running count across gaps, returns the total.
module vmask_cpop_seq #(
   parameter int DATA_WIDTH      = 64,
   parameter int DATA_WIDTH_BITS = 6,
   parameter int VL_BITS         = 16
) (
   input  logic              clk,
   input  logic              rst,
   vmask_cpop_seq_if.slave   bus
);
   localparam int BI_W = VL_BITS - DATA_WIDTH_BITS + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                     state, state_nxt;
   logic [VL_BITS-1:0]         vl_q;
   logic                       vm_q;
   logic [DATA_WIDTH-1:0]      acc;
   logic [DATA_WIDTH-1:0]      res_q;
   logic [BI_W-1:0]            beat_idx;
   logic                       issued_d;

   logic [VL_BITS:0]           vl_round;
   logic [BI_W-1:0]            n_beats;
   logic                       last_beat;
   logic [DATA_WIDTH_BITS-1:0] rem;
   logic [DATA_WIDTH-1:0]      tail;
   logic [DATA_WIDTH-1:0]      v0_mask;
   logic [DATA_WIDTH-1:0]      run_count;

   assign vl_round  = {1'b0, vl_q} + (VL_BITS+1)'(DATA_WIDTH - 1);
   assign n_beats   = vl_round[VL_BITS:DATA_WIDTH_BITS];
   assign last_beat = (beat_idx == n_beats - BI_W'(1));
   assign rem       = vl_q[DATA_WIDTH_BITS-1:0];
   // A zero remainder means the last beat is completely active.
   assign tail      = (last_beat && rem != '0) ? ~({DATA_WIDTH{1'b1}} << rem) : '1;
   assign v0_mask   = vm_q ? '1 : bus.src_v0;
   // The popcount stage zeroes its output on idle cycles, so after a gap the
   // count must come from acc rather than pc_sum.
   assign run_count = issued_d ? bus.pc_sum : acc;

   assign bus.res_data = res_q;

   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      bus.src_ready = 1'b0;
      bus.pc_valid  = 1'b0;
      bus.pc_m0     = '0;
      bus.pc_count  = '0;
      bus.res_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid)
               state_nxt = (bus.req_vl == '0) ? DONE : RUN;
         end
         RUN: begin
            bus.src_ready = 1'b1;
            bus.pc_valid  = bus.src_valid;
            if (bus.src_valid) begin
               bus.pc_m0    = bus.src_mask & v0_mask & tail;
               bus.pc_count = run_count;
               if (last_beat)
                  state_nxt = DRAIN;
            end
         end
         DRAIN: state_nxt = DONE;
         DONE: begin
            bus.res_valid = 1'b1;
            if (bus.res_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         vl_q     <= '0;
         vm_q     <= 1'b0;
         acc      <= '0;
         beat_idx <= '0;
         issued_d <= 1'b0;
         res_q    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  vl_q     <= bus.req_vl;
                  vm_q     <= bus.req_vm;
                  acc      <= '0;
                  beat_idx <= '0;
                  issued_d <= 1'b0;
                  if (bus.req_vl == '0)
                     res_q <= '0;
               end
            end
            RUN: begin
               acc      <= run_count;
               issued_d <= bus.src_valid;
               if (bus.src_valid)
                  beat_idx <= beat_idx + BI_W'(1);
            end
            // issued_d is 1 here, so pc_sum holds the final total.
            DRAIN: res_q <= bus.pc_sum;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_vmask_cpop_seq.sv
// Bench for vmask_cpop_seq: directed table plus random requests checked
// against an element-level reference of vcpop.m.
module tb_vmask_cpop_seq;
   localparam int DW  = 64;
   localparam int DWB = 6;
   localparam int VLB = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vmask_cpop_seq_if #(.DATA_WIDTH(DW), .VL_BITS(VLB)) bus ();

   vmask_cpop_seq #(.DATA_WIDTH(DW), .DATA_WIDTH_BITS(DWB), .VL_BITS(VLB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Popcount stage model
   always @(posedge clk) begin
      if (rst) bus.pc_sum <= '0;
      else     bus.pc_sum <= bus.pc_valid ? bus.pc_count + 64'($countones(bus.pc_m0)) : '0;
   end

   int checks = 0;
   int errors = 0;
   logic [63:0] mq[$];
   logic [63:0] vq[$];

   typedef struct {
      int          vl;
      bit          vm;
      logic [63:0] mask;
      logic [63:0] v0;
      int          gap;
      int          hold;
      logic [63:0] exp;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
      checks++;
      if (act !== ex) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, ex);
      end
   endtask

   // Active elements of beat w: element index below vl, mask bit set, and v0 set when masked.
   function automatic logic [63:0] ref_beat(input int w, input int vl, input bit vm);
      logic [63:0] m, v, r;
      m = mq[w];
      v = vq[w];
      r = '0;
      for (int b = 0; b < 64; b++)
         r[b] = ((w * 64 + b) < vl) && m[b] && (vm || v[b]);
      return r;
   endfunction

   function automatic logic [63:0] ref_count(input int vl, input bit vm);
      logic [63:0] n, m, v;
      n = '0;
      for (int i = 0; i < vl; i++) begin
         m = mq[i / 64];
         v = vq[i / 64];
         if (m[i % 64] && (vm || v[i % 64])) n++;
      end
      return n;
   endfunction

   task automatic do_req(input int vl, input bit vm, input int gap, input int hold,
                         input logic [63:0] exp);
      int          nb;
      int          cyc;
      logic [63:0] run, bm, held;
      nb  = (vl + 63) / 64;
      run = '0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_vl    = 16'(vl);
      bus.req_vm    = vm;
      #1 chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int b = 0; b < nb; b++) begin
         bus.src_valid = 1'b1;
         bus.src_mask  = mq[b];
         bus.src_v0    = vq[b];
         bm = ref_beat(b, vl, vm);
         #1;
         chk("src_ready_run", 64'(bus.src_ready), 64'd1);
         chk("pc_m0", bus.pc_m0, bm);
         chk("pc_count", bus.pc_count, run);
         run += 64'($countones(bm));
         @(negedge clk);
         bus.src_valid = 1'b0;
         bus.src_mask  = $urandom;
         if (b < nb - 1) repeat (gap) @(negedge clk);
      end
      cyc = 0;
      while (!bus.res_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (!bus.res_valid) begin
         errors++;
         checks++;
         $display("FAIL res_timeout: res_valid still %b after %0d cycles", bus.res_valid, cyc);
      end else if (nb == 0) begin
         chk("latency_vl0", 64'(cyc), 64'd0);
         chk("src_ready_vl0", 64'(bus.src_ready), 64'd0);
      end else if (gap == 0) begin
         chk("latency", 64'(cyc), 64'd1);
      end
      chk("res_data", bus.res_data, exp);
      held = exp;
      repeat (hold) begin
         @(negedge clk);
         chk("hold_res_valid", 64'(bus.res_valid), 64'd1);
         chk("hold_res_data", bus.res_data, held);
         chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      #1;
      chk("idle_req_ready", 64'(bus.req_ready), 64'd1);
      chk("idle_res_valid", 64'(bus.res_valid), 64'd0);
   endtask

   vec_t vec[5];

   initial begin
      vec[0] = '{vl: 128, vm: 1'b1, mask: '1,     v0: '0,                    gap: 0, hold: 0, exp: 64'd128};
      vec[1] = '{vl: 70,  vm: 1'b1, mask: '1,     v0: '0,                    gap: 0, hold: 0, exp: 64'd70};
      vec[2] = '{vl: 64,  vm: 1'b0, mask: '1,     v0: 64'h5555_5555_5555_5555, gap: 0, hold: 1, exp: 64'd32};
      vec[3] = '{vl: 192, vm: 1'b1, mask: 64'hFF, v0: '0,                    gap: 2, hold: 0, exp: 64'd24};
      vec[4] = '{vl: 0,   vm: 1'b1, mask: '0,     v0: '0,                    gap: 0, hold: 5, exp: 64'd0};

      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_vl = '0; bus.req_vm = 1'b0;
      bus.src_valid = 1'b0; bus.src_mask = '0; bus.src_v0 = '0;
      bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_src_ready", 64'(bus.src_ready), 64'd0);
      chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
      chk("rst_res_data", bus.res_data, 64'd0);
      rst = 1'b0;

      foreach (vec[i]) begin
         mq.delete();
         vq.delete();
         for (int b = 0; b < (vec[i].vl + 63) / 64; b++) begin
            mq.push_back(vec[i].mask);
            vq.push_back(vec[i].v0);
         end
         do_req(vec[i].vl, vec[i].vm, vec[i].gap, vec[i].hold, vec[i].exp);
      end

      // Reset in the middle of a vl=128 request
      mq.delete(); vq.delete();
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_vl = 16'd128; bus.req_vm = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.src_valid = 1'b1; bus.src_mask = '1; bus.src_v0 = '0;
      @(negedge clk);
      bus.src_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("mid_rst_src_ready", 64'(bus.src_ready), 64'd0);
      chk("mid_rst_pc_valid", 64'(bus.pc_valid), 64'd0);
      chk("mid_rst_pc_m0", bus.pc_m0, 64'd0);
      chk("mid_rst_pc_count", bus.pc_count, 64'd0);
      chk("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
      chk("mid_rst_res_data", bus.res_data, 64'd0);
      mq.push_back('1); vq.push_back('0);
      do_req(64, 1'b1, 0, 0, 64'd64);

      // Random requests: tail bits beyond vl are random, so they must be masked off
      for (int t = 0; t < 30; t++) begin
         int vl;
         bit vm;
         vl = $urandom_range(0, 320);
         vm = 1'($urandom_range(0, 1));
         mq.delete(); vq.delete();
         for (int b = 0; b < (vl + 63) / 64; b++) begin
            mq.push_back({$urandom, $urandom});
            vq.push_back({$urandom, $urandom});
         end
         do_req(vl, vm, $urandom_range(0, 2), $urandom_range(0, 2), ref_count(vl, vm));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vmask_cpop_seq.md
Name: vmask_cpop_seq

Overview:
Sequencer for vcpop.m that sits directly upstream of the one-cycle mask popcount stage. It accepts a request carrying vl and vm, then streams the mask operand beat by beat from the operand source. For each beat it applies v0 masking and tail masking, drives the popcount stage, and keeps a running count that survives gaps between beats. When all beats are done it returns the final scalar count through a valid/ready result port.

Parameters:
DATA_WIDTH, 64, mask bits per beat; also the width of all count paths.
DATA_WIDTH_BITS, 6, log2(DATA_WIDTH).
VL_BITS, 16, width of req_vl.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  new vcpop request
req_ready  output  1  high only in IDLE
req_vl  input  VL_BITS  number of active mask bits
req_vm  input  1  1 = unmasked, 0 = AND each beat with src_v0
src_valid  input  1  mask beat available
src_ready  output  1  beat accepted when src_valid && src_ready
src_mask  input  DATA_WIDTH  mask operand beat, bit 0 = lowest element
src_v0  input  DATA_WIDTH  matching v0 beat
pc_m0  output  DATA_WIDTH  masked beat to popcount stage
pc_valid  output  1  beat issued to popcount stage
pc_count  output  DATA_WIDTH  running count to popcount stage
pc_sum  input  DATA_WIDTH  popcount stage result (count of previous issue + popcount of it), valid the cycle after pc_valid
res_valid  output  1  final count available
res_data  output  DATA_WIDTH  final count
res_ready  input  1  result consumed

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. On reset: state IDLE; acc, beat index, issued_d and res_data cleared to 0; req_ready=1; src_ready, pc_valid, res_valid = 0; pc_m0 and pc_count = 0.
- A reset asserted mid-operation abandons the request. No result is produced.
- State IDLE:
  - req_ready=1.
  - On req_valid, latch vl and vm, clear acc, beat index and issued_d.
  - If vl==0, go to DONE with res_data=0, and no beats are consumed.
  - Otherwise go to RUN.
- State RUN:
  - src_ready=1.
  - pc_valid = src_valid, combinational.
  - pc_m0 = src_mask & (vm ? all-ones : src_v0) & tail.
  - tail is all-ones except on the last beat, where it keeps the low (vl mod DATA_WIDTH) bits. If vl mod DATA_WIDTH == 0, the last beat is full.
  - Beat count = ceil(vl/DATA_WIDTH).
  - pc_count = issued_d ? pc_sum : acc.
  - Every cycle: acc <= (issued_d ? pc_sum : acc), and issued_d <= pc_valid.
  - This keeps the count correct across src_valid gaps; the popcount stage zeroes its count when its valid input is low.
  - pc_m0 and pc_count are driven 0 whenever pc_valid=0.
  - When the last beat is accepted, go to DRAIN.
- State DRAIN:
  - Lasts 1 cycle; src_ready=0.
  - res_data <= pc_sum, which holds the total because issued_d is 1 here. Go to DONE.
- State DONE:
  - res_valid=1; res_data held stable.
  - On res_ready, go to IDLE.
  - req_ready=0 until then, so a new request is never accepted on the same cycle as the result handshake.
- Latency:
  - For N back-to-back beats, res_valid rises N+1 cycles after the first beat is accepted.
  - For vl==0, res_valid is high the cycle after req acceptance.
- Widths:
  - All accumulation is DATA_WIDTH wide and unsigned.
  - Max result is 2^VL_BITS − 1, so there is no overflow for VL_BITS < DATA_WIDTH.
  - Beat index is VL_BITS−DATA_WIDTH_BITS+1 bits.
- src_valid low in RUN: no issue, acc holds, state holds.
- Bits of src_mask beyond vl never contribute, regardless of their value.

Test Plan:
Bench models the popcount stage: pc_sum(t+1) = pc_valid(t) ? popcount(pc_m0)+pc_count : 0.
- vl=128, vm=1, two back-to-back all-ones beats -> res_data=128, res_valid 3 cycles after first beat accepted.
- vl=70, vm=1, two all-ones beats -> second pc_m0=0x3F, res_data=70.
- vl=64, vm=0, src_mask=all-ones, src_v0=0x5555_5555_5555_5555 -> res_data=32.
- vl=192, vm=1, three beats of 0xFF with src_valid low for 2 cycles between each beat -> res_data=24, acc not lost.
- vl=0 -> src_ready never asserted, res_data=0 next cycle; hold res_ready=0 for 5 cycles -> res_valid and res_data stable, req_ready=0; then res_ready=1 -> IDLE.
- rst asserted in RUN after one beat of vl=128 -> next cycle IDLE, all outputs 0; a new request for vl=64 all-ones -> 64.
